adaptive_noise_subtractor: RTL and testbench

Parametrised successor to the single-shot noise-floor subtraction stage in the hearing-aid audio chain. Sits after the input decimator and before the gain/compression stage. Estimates the noise floor as the mean absolute value over a power-of-two window. Subtracts a programmable multiple of that floor from each sample's magnitude, with three modes: bypass, fixed (estimate once, then freeze) and tracking (estimate updated once per window by exponential smoothing).

---
 rtl/ans_pkg.sv | 13 +
 rtl/noise_window_accumulator.sv | 47 ++++
 rtl/adaptive_noise_subtractor.sv | 140 ++++++++++++++
 tb/tb_adaptive_noise_subtractor.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ans_pkg.sv
// Shared encodings for the adaptive noise-floor subtraction stage.
package ans_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_FIXED  = 2'd1;
    localparam logic [1:0] MODE_TRACK  = 2'd2;

    typedef enum logic {CAL, RUN} state_t;

    // oversub is unsigned Q2.2: two fractional bits
    localparam int OVERSUB_FRAC = 2;

endpackage

// File: rtl/noise_window_accumulator.sv
// Sums sample magnitudes over a 2^LOG2_LEN window; win_mean/win_done are
// combinational on the valid cycle that completes the window.
module noise_window_accumulator #(
    parameter int DATA_W   = 16,
    parameter int LOG2_LEN = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-2:0] mag,
    input  logic              valid,
    input  logic              clear,
    output logic [DATA_W-2:0] win_mean,
    output logic              win_done
);

    localparam int ACC_W = DATA_W - 1 + LOG2_LEN;

    logic [ACC_W-1:0]    acc_q, acc_d, acc_sum;
    logic [LOG2_LEN-1:0] cnt_q, cnt_d;

    always_comb begin
        acc_sum  = acc_q + ACC_W'(mag);
        win_done = valid && !clear && (cnt_q == '1);
        win_mean = acc_sum[ACC_W-1:LOG2_LEN];
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        // clear discards any coincident sample
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (valid) begin
            acc_d = win_done ? '0 : acc_sum;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adaptive_noise_subtractor.sv
// Noise-floor estimator (calibrate / track) and magnitude subtraction with
// programmable over-subtraction; one cycle of latency from audio_valid.
module adaptive_noise_subtractor
    import ans_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int LOG2_LEN    = 8,
    parameter int ALPHA_SHIFT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] audio_in,
    input  logic              audio_valid,
    input  logic [1:0]        mode,
    input  logic [3:0]        oversub,
    input  logic              recal,
    output logic [DATA_W-1:0] audio_out,
    output logic              audio_ready,
    output logic [DATA_W-2:0] noise_est,
    output logic              noise_ready
);

    localparam logic [DATA_W-2:0] MAG_MAX = '1;

    function automatic logic [DATA_W-2:0] sat_mag(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] a;
        a = x[DATA_W-1] ? (~x + 1'b1) : x;
        return a[DATA_W-1] ? MAG_MAX : a[DATA_W-2:0];
    endfunction

    function automatic logic [DATA_W-2:0] sat_thresh(input logic [DATA_W+2:0] prod);
        logic [DATA_W:0] s;
        s = prod[DATA_W+2:OVERSUB_FRAC];
        return (|s[DATA_W:DATA_W-1]) ? MAG_MAX : s[DATA_W-2:0];
    endfunction

    function automatic logic [DATA_W-2:0] clamp_est(input logic signed [DATA_W:0] v);
        if (v[DATA_W])        return '0;
        else if (v[DATA_W-1]) return MAG_MAX;
        else                  return v[DATA_W-2:0];
    endfunction

    state_t            state_q, state_d;
    logic [DATA_W-2:0] noise_est_q, noise_est_d;
    logic              noise_ready_q, noise_ready_d;
    logic [DATA_W-1:0] audio_out_q, audio_out_d;
    logic              audio_ready_q, audio_ready_d;

    logic [1:0]        mode_eff;
    logic              tracking, bypass, acc_valid, acc_clear, win_done;
    logic [DATA_W-2:0] mag, thr, sub, win_mean;
    logic [DATA_W-1:0] sub_res;
    logic signed [DATA_W:0] diff, step, upd;

    always_comb begin
        mode_eff  = (mode == 2'd3) ? MODE_FIXED : mode;
        tracking  = (mode_eff == MODE_TRACK);
        bypass    = (mode_eff == MODE_BYPASS);
        acc_valid = audio_valid && !recal && (state_q == CAL || tracking);
        // leaving tracking empties the window so re-entry starts fresh
        acc_clear = recal || (state_q == RUN && audio_valid && !tracking);
    end

    noise_window_accumulator #(
        .DATA_W   (DATA_W),
        .LOG2_LEN (LOG2_LEN)
    ) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .mag      (mag),
        .valid    (acc_valid),
        .clear    (acc_clear),
        .win_mean (win_mean),
        .win_done (win_done)
    );

    always_comb begin
        mag     = sat_mag(audio_in);
        thr     = sat_thresh((DATA_W+3)'(noise_est_q) * (DATA_W+3)'(oversub));
        sub     = mag - thr;
        sub_res = '0;
        if (mag > thr) begin
            sub_res = audio_in[DATA_W-1] ? (~{1'b0, sub} + 1'b1) : {1'b0, sub};
        end
        diff = $signed({2'b00, win_mean}) - $signed({2'b00, noise_est_q});
        step = diff >>> ALPHA_SHIFT;
        upd  = $signed({2'b00, noise_est_q}) + step;
    end

    always_comb begin
        state_d       = state_q;
        noise_est_d   = noise_est_q;
        noise_ready_d = noise_ready_q;
        audio_out_d   = audio_out_q;
        audio_ready_d = 1'b0;
        if (audio_valid) begin
            if (bypass) begin
                audio_out_d   = audio_in;
                audio_ready_d = 1'b1;
            end else if (state_q == RUN && !recal) begin
                audio_out_d   = sub_res;
                audio_ready_d = 1'b1;
            end
        end
        if (recal) begin
            state_d       = CAL;
            noise_ready_d = 1'b0;
        end else if (win_done) begin
            if (state_q == CAL) begin
                noise_est_d   = win_mean;
                noise_ready_d = 1'b1;
                state_d       = RUN;
            end else begin
                noise_est_d = clamp_est(upd);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= CAL;
            noise_est_q   <= '0;
            noise_ready_q <= 1'b0;
            audio_out_q   <= '0;
            audio_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            noise_est_q   <= noise_est_d;
            noise_ready_q <= noise_ready_d;
            audio_out_q   <= audio_out_d;
            audio_ready_q <= audio_ready_d;
        end
    end

    assign audio_out   = audio_out_q;
    assign audio_ready = audio_ready_q;
    assign noise_est   = noise_est_q;
    assign noise_ready = noise_ready_q;

endmodule

// File: tb/tb_adaptive_noise_subtractor.sv
// Directed bench with an output scoreboard (value and arrival cycle).
module tb_adaptive_noise_subtractor;

    localparam logic [1:0] B = 2'd0;
    localparam logic [1:0] F = 2'd1;
    localparam logic [1:0] T = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] audio_in;
    logic        audio_valid;
    logic [1:0]  mode;
    logic [3:0]  oversub;
    logic        recal;
    logic [15:0] audio_out;
    logic        audio_ready;
    logic [14:0] noise_est;
    logic        noise_ready;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] val;
        int          at;
    } exp_t;
    exp_t q[$];
    exp_t e_mon;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adaptive_noise_subtractor #(
        .DATA_W      (16),
        .LOG2_LEN    (2),
        .ALPHA_SHIFT (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .audio_in    (audio_in),
        .audio_valid (audio_valid),
        .mode        (mode),
        .oversub     (oversub),
        .recal       (recal),
        .audio_out   (audio_out),
        .audio_ready (audio_ready),
        .noise_est   (noise_est),
        .noise_ready (noise_ready)
    );

    always @(negedge clk) begin
        if (rst_n === 1'b1 && audio_ready === 1'b1) begin
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_ready observed=%0d expected no strobe", $signed(audio_out));
            end
            if (q.size() != 0) begin
                e_mon = q.pop_front();
                checks++;
                assert (audio_out === e_mon.val) else begin
                    errors++;
                    $error("FAIL audio_out observed=%0d expected=%0d", $signed(audio_out), $signed(e_mon.val));
                end
                checks++;
                assert (cyc === e_mon.at) else begin
                    errors++;
                    $error("FAIL latency observed_cycle=%0d expected_cycle=%0d", cyc, e_mon.at);
                end
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int x, input logic [1:0] m, input logic [3:0] os,
                        input logic rc, input logic has_exp, input int ex);
        exp_t e;
        @(negedge clk);
        audio_in    = 16'(x);
        audio_valid = 1'b1;
        mode        = m;
        oversub     = os;
        recal       = rc;
        if (has_exp) begin
            e.val = 16'(ex);
            e.at  = cyc + 1;
            q.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        audio_valid = 1'b0;
        recal       = 1'b0;
    endtask

    task automatic recal_pulse();
        @(negedge clk);
        audio_valid = 1'b0;
        recal       = 1'b1;
        idle();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_audio_out"}, int'(audio_out), 0);
        chk({tag, "_audio_ready"}, int'(audio_ready), 0);
        chk({tag, "_noise_est"}, int'(noise_est), 0);
        chk({tag, "_noise_ready"}, int'(noise_ready), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; audio_in = '0; audio_valid = 1'b0;
        mode = F; oversub = 4'd4; recal = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // calibration in fixed mode, then subtraction at 1.0 / 2.0 / 3.75
        send(100, F, 4, 0, 0, 0); send(-100, F, 4, 0, 0, 0);
        send(100, F, 4, 0, 0, 0); send(-100, F, 4, 0, 0, 0);
        idle();
        chk("cal_est", int'(noise_est), 100);
        chk("cal_ready", int'(noise_ready), 1);
        send(300, F, 4, 0, 1, 200); send(-250, F, 4, 0, 1, -150);
        send(50, F, 4, 0, 1, 0);    send(-100, F, 4, 0, 1, 0);
        send(300, F, 8, 0, 1, 100); send(-201, F, 8, 0, 1, -1);
        send(200, F, 8, 0, 1, 0);   send(400, F, 15, 0, 1, 25);

        // tracking: 100 -> 200 -> 100
        send(300, T, 4, 0, 1, 200); send(-300, T, 4, 0, 1, -200);
        send(300, T, 4, 0, 1, 200); send(-300, T, 4, 0, 1, -200);
        idle();
        chk("track_up", int'(noise_est), 200);
        repeat (4) send(0, T, 4, 0, 1, 0);
        idle();
        chk("track_down", int'(noise_est), 100);

        // recal on a valid sample in fixed mode, then saturating window
        send(0, F, 4, 1, 0, 0);
        idle();
        chk("recal_ready", int'(noise_ready), 0);
        chk("recal_hold", int'(noise_est), 100);
        repeat (4) send(-32768, F, 4, 0, 0, 0);
        idle();
        chk("sat_est", int'(noise_est), 32767);
        chk("sat_ready", int'(noise_ready), 1);
        send(32767, F, 15, 0, 1, 0); send(-32768, F, 15, 0, 1, 0);

        // bypass during CAL; recal on a bypass sample still echoes it
        recal_pulse();
        chk("recal2_ready", int'(noise_ready), 0);
        chk("recal2_hold", int'(noise_est), 32767);
        send(5, B, 4, 0, 1, 5); send(-7, B, 4, 0, 1, -7);
        send(9, B, 4, 1, 1, 9);
        idle();
        chk("byp_recal_ready", int'(noise_ready), 0);
        chk("byp_recal_hold", int'(noise_est), 32767);
        send(40, B, 4, 0, 1, 40); send(-40, B, 4, 0, 1, -40);
        send(40, B, 4, 0, 1, 40); send(-40, B, 4, 0, 1, -40);
        idle();
        chk("byp_est", int'(noise_est), 40);
        chk("byp_ready", int'(noise_ready), 1);
        send(123, B, 4, 0, 1, 123);
        send(50, F, 4, 0, 1, 10);
        send(-50, 2'd3, 4, 0, 1, -10);
        idle();
        chk("run_bypass_no_track", int'(noise_est), 40);

        // asynchronous reset mid-window
        recal_pulse();
        send(1000, F, 4, 0, 0, 0); send(1000, F, 4, 0, 0, 0);
        @(negedge clk);
        audio_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) send(8, F, 4, 0, 0, 0);
        idle();
        chk("post_reset_est", int'(noise_est), 8);
        chk("post_reset_ready", int'(noise_ready), 1);

        repeat (3) idle();
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
